// File: rtl/dmem_port_if.sv
// rtl/dmem_port_if.sv - requester, memory and error signals of the data-memory port arbiter
//
// Groups every non-clock signal of dmem_port_arbiter.
//   p_*      pipeline memory-stage request / completion
//   l_*      program/debug loader request / completion
//   mem_*    single data-memory port (req/ack handshake)
//   err_*    sticky watchdog flag and its clear
// slave  : arbiter view (drives completions, mem request, error flag)
// master : environment view (drives requests, memory response, err_clr)
interface dmem_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          p_req;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [DW-1:0] p_rdata;
  logic          p_done;
  logic          stall;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] l_rdata;
  logic          l_done;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          err_timeout;
  logic          err_clr;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_done, stall,
    input  l_req, l_we, l_addr, l_wdata,
    output l_rdata, l_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output err_timeout,
    input  err_clr
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_done, stall,
    output l_req, l_we, l_addr, l_wdata,
    input  l_rdata, l_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  err_timeout,
    output err_clr
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between pipeline (P) and loader (L)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_port_if.slave: p_* / l_* requesters, mem_* port, err_timeout / err_clr
//
// One access at a time: IDLE arbitrates, BUSY_P/BUSY_L hold mem_req with the
// latched request until mem_ack or watchdog expiry, DONE pulses the owner's done.
// P normally wins; L is forced through after MAX_WAIT refusals.
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_port_if.slave bus
);

  localparam int WAITW = $clog2(MAX_WAIT + 1);
  localparam int WDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAITW-1:0] WAIT_MAX = WAITW'(MAX_WAIT);
  // Watchdog fires in the BUSY cycle whose count (before increment) is TIMEOUT-1,
  // i.e. mem_req has then been high for exactly TIMEOUT cycles.
  localparam logic [WDW-1:0]   WD_LAST  = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY_P, BUSY_L, DONE} state_t;

  state_t           state_q;
  logic [WAITW-1:0] wait_cnt_q;
  logic [WDW-1:0]   wd_cnt_q;
  logic             mem_req_q;
  logic             hold_we_q;
  logic [AW-1:0]    hold_addr_q;
  logic [DW-1:0]    hold_wdata_q;
  logic             p_done_q;
  logic             l_done_q;
  logic [DW-1:0]    p_rdata_q;
  logic [DW-1:0]    l_rdata_q;
  logic             err_q;

  logic grant_l;
  logic wd_hit;
  logic [DW-1:0] rdata_d;

  // L wins when alone or when it has been refused MAX_WAIT times.
  assign grant_l = bus.l_req & (~bus.p_req | (wait_cnt_q == WAIT_MAX));
  assign wd_hit  = (TIMEOUT > 0) && (wd_cnt_q == WD_LAST);
  assign rdata_d = hold_we_q ? '0 : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      mem_req_q    <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      p_done_q     <= 1'b0;
      l_done_q     <= 1'b0;
      p_rdata_q    <= '0;
      l_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      // Completion outputs are single-cycle; rdata reads as zero outside DONE.
      p_done_q  <= 1'b0;
      l_done_q  <= 1'b0;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
      if (bus.err_clr) begin
        err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (grant_l) begin
            state_q      <= BUSY_L;
            mem_req_q    <= 1'b1;
            hold_we_q    <= bus.l_we;
            hold_addr_q  <= bus.l_addr;
            hold_wdata_q <= bus.l_wdata;
            wait_cnt_q   <= '0;
          end else if (bus.p_req) begin
            state_q      <= BUSY_P;
            mem_req_q    <= 1'b1;
            hold_we_q    <= bus.p_we;
            hold_addr_q  <= bus.p_addr;
            hold_wdata_q <= bus.p_wdata;
            if (bus.l_req && wait_cnt_q != WAIT_MAX) begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end

        BUSY_P, BUSY_L: begin
          // Ack takes priority over an expiring watchdog in the same cycle.
          if (bus.mem_ack || wd_hit) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            wd_cnt_q  <= '0;
            if (state_q == BUSY_P) begin
              p_done_q  <= 1'b1;
              p_rdata_q <= bus.mem_ack ? rdata_d : '0;
            end else begin
              l_done_q  <= 1'b1;
              l_rdata_q <= bus.mem_ack ? rdata_d : '0;
            end
            if (!bus.mem_ack) begin
              err_q <= 1'b1;
            end
          end else if (TIMEOUT > 0) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.p_done      = p_done_q;
  assign bus.l_done      = l_done_q;
  assign bus.p_rdata     = p_rdata_q;
  assign bus.l_rdata     = l_rdata_q;
  assign bus.stall       = bus.p_req & ~p_done_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = hold_we_q;
  assign bus.mem_addr    = hold_addr_q;
  assign bus.mem_wdata   = hold_wdata_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_if #(.AW(32), .DW(32)) bus ();

  dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_l;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // memory responder controls (written at negedges, read at posedge+1)
  bit ack_en  = 1'b1;
  int ack_lat = 1;
  int clr_at  = 0;
  bit clr_req = 1'b0;
  int busy    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_2468;
  endfunction

  task automatic push(input bit is_l, input logic [31:0] d);
    exp_t e;
    e.is_l  = is_l;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input bit is_l, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_l ? bus.l_done : bus.p_done) && cyc < max);
    check_eq(is_l ? "l_done_seen" : "p_done_seen", is_l ? bus.l_done : bus.p_done, 1);
  endtask

  task automatic wait_any(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.p_done || bus.l_done) && cyc < max);
    check_eq("any_done_seen", bus.p_done | bus.l_done, 1);
  endtask

  // Memory model: ack after ack_lat cycles of mem_req, data derived from address.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.err_clr   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) busy++;
      else busy = 0;
      bus.mem_ack   = ack_en && bus.mem_req && (busy == ack_lat);
      bus.err_clr   = clr_req || (clr_at != 0 && bus.mem_req && busy == clr_at);
      bus.mem_rdata = mem_model(bus.mem_addr);
    end
  end

  // Scoreboard: every completion pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.p_done || bus.l_done)) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", {bus.l_done, bus.p_done}, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("done_port", {bus.l_done, bus.p_done}, e.is_l ? 2'b10 : 2'b01);
          check_eq("done_rdata", e.is_l ? bus.l_rdata : bus.p_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    int cnt;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_dones", {bus.p_done, bus.l_done}, 0);
    check_eq("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    check_eq("rst_rdata", {bus.p_rdata, bus.l_rdata}, 0);
    check_eq("rst_err_stall", {bus.err_timeout, bus.stall}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: P load, ack two cycles after mem_req rises
    ack_lat = 3;
    bus.p_we = 0; bus.p_addr = 32'h100; bus.p_req = 1;
    push(0, mem_model(32'h100));
    #1 check_eq("t1_stall_req", bus.stall, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t1_mem_req", bus.mem_req, 1);
      check_eq("t1_mem_addr", bus.mem_addr, 32'h100);
      check_eq("t1_stall_busy", bus.stall, 1);
    end
    @(negedge clk);
    check_eq("t1_p_done", bus.p_done, 1);
    check_eq("t1_stall_done", bus.stall, 0);
    check_eq("t1_mem_req_done", bus.mem_req, 0);
    bus.p_req = 0;
    @(negedge clk);

    // 2: both requesting, zero-wait memory -> P x4, L, P x4, L
    ack_lat = 1;
    bus.p_addr = 32'h200; bus.l_addr = 32'h300; bus.l_we = 0;
    bus.p_req = 1; bus.l_req = 1;
    for (int k = 0; k < 10; k++) push((k % 5) == 4, mem_model((k % 5) == 4 ? 32'h300 : 32'h200));
    for (int k = 0; k < 10; k++) begin
      wait_any(8, cyc);
      check_eq("t2_gap", cyc, (k == 0) ? 2 : 3);
    end
    bus.p_req = 0; bus.l_req = 0;
    @(negedge clk);
    @(negedge clk);

    // 3: L store while P arrives mid-access
    ack_lat = 4;
    bus.l_we = 1; bus.l_addr = 32'h20; bus.l_wdata = 32'hCAFEF00D; bus.l_req = 1;
    push(1, 32'h0);
    @(negedge clk);
    bus.p_we = 0; bus.p_addr = 32'h40; bus.p_req = 1;
    push(0, mem_model(32'h40));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_mem_req", bus.mem_req, 1);
      check_eq("t3_mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h20, 32'hCAFEF00D});
      check_eq("t3_stall", bus.stall, 1);
    end
    @(negedge clk);
    check_eq("t3_l_done", bus.l_done, 1);
    bus.l_req = 0;
    wait_done(0, 12, cyc);
    check_eq("t3_p_after_l", cyc, 6);
    bus.p_req = 0;
    @(negedge clk);

    // 4: watchdog expiry; err_clr in the expiry cycle loses to the set
    ack_en = 0; clr_at = 16;
    bus.p_we = 0; bus.p_addr = 32'h80; bus.p_req = 1;
    push(0, 32'h0);
    cnt = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) cnt++;
    end while (!bus.p_done && cyc < 40);
    check_eq("t4_done_cycle", cyc, 17);
    check_eq("t4_req_cycles", cnt, 16);
    check_eq("t4_err_set", bus.err_timeout, 1);
    bus.p_req = 0; clr_at = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_err_sticky", bus.err_timeout, 1);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    @(negedge clk);
    check_eq("t4_err_clr", bus.err_timeout, 0);

    // 5: ack lands on the 16th BUSY cycle, with err_clr -> success
    ack_en = 1; ack_lat = 16; clr_at = 16;
    bus.p_addr = 32'hF0; bus.p_req = 1;
    push(0, mem_model(32'hF0));
    wait_done(0, 30, cyc);
    check_eq("t5_done_cycle", cyc, 17);
    check_eq("t5_err", bus.err_timeout, 0);
    bus.p_req = 0; clr_at = 0;
    @(negedge clk);
    check_eq("t5_err_after", bus.err_timeout, 0);

    // 6: reset mid-access, then a clean access
    ack_en = 0;
    bus.p_addr = 32'h180; bus.p_req = 1;
    push(0, mem_model(32'h180));
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_busy", bus.mem_req, 1);
    rst_n = 0;
    #1;
    check_eq("t6_rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    check_eq("t6_rst_done", {bus.p_done, bus.l_done, bus.err_timeout}, 0);
    void'(exp_q.pop_front());
    bus.p_req = 0;
    @(negedge clk);
    rst_n = 1; ack_en = 1; ack_lat = 2;
    @(negedge clk);
    bus.p_addr = 32'h1C0; bus.p_req = 1;
    push(0, mem_model(32'h1C0));
    wait_done(0, 10, cyc);
    check_eq("t6_clean_cycle", cyc, 3);
    bus.p_req = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
